uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver, the receive-side counterpart of the team's UART TX chain (serializer plus parity_calc).
- Oversamples RX_IN, majority-votes the centre of each bit and deserializes LSB-first into P_DATA.
- Checks optional even/odd parity and the stop bit.
- Sits between the pad-side serial input and the system-side parallel consumer (e.g. RX FIFO or register file).

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line; idle high; asynchronous to clk.
Prescale  input  6  oversampling ratio; 8, 16 or 32 supported.
PAR_EN  input  1  1 = parity bit present after data.
PAR_TYP  input  1  0 = even parity, 1 = odd parity (same encoding as TX).
P_DATA  output  DATA_WIDTH  last correctly received word.
data_vld  output  1  one-cycle pulse, P_DATA updated.
par_err  output  1  one-cycle pulse, parity mismatch in frame just ended.
stp_err  output  1  one-cycle pulse, stop bit sampled low.

Behaviour:
- Reset state: synchronous on rising edge of clk with reset=1.
  - Outputs: P_DATA=0, data_vld=0, par_err=0, stp_err=0.
  - FSM goes to IDLE; counters are 0; synchronizer flops are 1.
  - Reset asserted mid-frame aborts the frame with no pulses.
- Input synchronizer: RX_IN passes through a 2-flop synchronizer. "rx_s" below denotes its output.
- Config capture: Prescale, PAR_EN and PAR_TYP are latched when the start is detected in IDLE. Changes mid-frame are ignored.
- Unsupported Prescale values (anything other than 8, 16 or 32) are treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 per bit (P = latched prescale).
  - bit_cnt counts data bits.
  - Samples are taken at edge_cnt = P/2-2, P/2-1 and P/2. The sampled bit is the majority of the three.
  - The bit decision is acted on at edge_cnt = P-1, where edge_cnt wraps to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 -> START, edge_cnt=0.
  - START: at edge_cnt=P-1, sampled bit 1 (glitch) -> IDLE with no pulses; else -> DATA with bit_cnt=0.
  - DATA: at edge_cnt=P-1, shift the sampled bit into the MSB of the shift register (LSB-first on the line). When bit_cnt = DATA_WIDTH-1, go to PARITY if PAR_EN else STOP; otherwise bit_cnt+1.
  - PARITY: at edge_cnt=P-1, compare the sampled bit with the expected parity (^shift for even, ~^shift for odd). Store the mismatch in par_flag. Go to STOP.
  - STOP: at edge_cnt=P-1, -> IDLE and issue the frame-end result on the next clock edge.
- Frame-end result (one-cycle pulses, registered):
  - stp_err = (stop sample == 0).
  - par_err = par_flag (always 0 when PAR_EN=0).
  - data_vld = 1 only if both are 0; P_DATA <= shift on that same edge.
  - On error, P_DATA holds its previous value.
  - par_err and stp_err may assert together.
- Latency: first data_vld/err edge occurs (1+DATA_WIDTH+PAR_EN+1)*P clocks after the IDLE cycle that sees rx_s=0, plus 1 clock register. RX_IN to rx_s adds 2 clocks.
- Back-to-back frames: IDLE is re-entered at the end of the stop bit. A start bit beginning immediately is detected within 1 clock and must be received correctly.
- Line held low (break): frame ends with stp_err=1. The FSM then restarts START detection while the line stays low, and each P*(frame length) yields another stp_err. No data_vld.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> one data_vld pulse, P_DATA=0xA5, par_err=0, stp_err=0, at 88 clocks + 1 after start detection.
- Same frame, parity bit driven 1 -> par_err pulse, data_vld stays 0, P_DATA keeps previous value. Then PAR_TYP=1 with parity 1 for 0xA5 -> data_vld, P_DATA=0xA5.
- Prescale=16, PAR_EN=0, 0x3C with stop bit 0 -> stp_err pulse, no data_vld. Next frame 0x3C with valid stop, sent back-to-back -> data_vld, P_DATA=0x3C.
- Prescale=32, 0x81 frame with single-clock glitches (1 clk inverted) placed on each sample-centre edge -> majority vote yields P_DATA=0x81, data_vld=1. Separately, a 5-clock low pulse on the idle line -> START rejects it, no pulses.
- Prescale changed 8->16 and PAR_EN toggled mid-frame -> current frame decoded with the latched config; the next frame uses the new config.
- reset=1 for 1 clock at the middle of DATA -> all outputs 0, FSM IDLE. Remainder of the aborted frame produces no data_vld; a following clean 0x5A frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver, its serial line and the parallel consumer.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_vld;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_vld, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_vld, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-voted bit centres, LSB-first deserialisation,
// optional even/odd parity check and stop-bit check with one-cycle result pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q;
  logic                  sync1_q, sync2_q;
  logic [5:0]            edge_cnt_q;
  logic [5:0]            presc_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  par_en_q, par_typ_q;
  logic [2:0]            samp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_flag_q, stop_bad_q, done_q;
  logic                  data_vld_q, par_err_q, stp_err_q;

  logic [5:0]            presc_d;
  logic [5:0]            half;
  logic                  last_edge;
  logic                  bit_d;
  logic                  par_exp_d;
  logic [DATA_WIDTH-1:0] shift_d;

  always_comb begin
    presc_d = 6'd8;
    if (bus.Prescale == 6'd16 || bus.Prescale == 6'd32) presc_d = bus.Prescale;
  end

  assign half      = presc_q >> 1;
  assign last_edge = (edge_cnt_q == presc_q - 6'd1);
  assign bit_d     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign shift_d   = {bit_d, shift_q[DATA_WIDTH-1:1]};
  assign par_exp_d = par_typ_q ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: synchronizer flops reset to the idle level so leaving reset never fakes a start bit.
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      presc_q    <= 6'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_flag_q <= 1'b0;
      stop_bad_q <= 1'b0;
      done_q     <= 1'b0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      sync1_q <= bus.RX_IN;
      sync2_q <= sync1_q;

      // NOTE: result pulses default low each cycle; only the frame-end branch raises them.
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      done_q     <= 1'b0;
      if (done_q) begin
        stp_err_q  <= stop_bad_q;
        par_err_q  <= par_flag_q;
        data_vld_q <= ~(stop_bad_q | par_flag_q);
        if (!(stop_bad_q | par_flag_q)) p_data_q <= shift_q;
      end

      if (state_q != IDLE) begin
        edge_cnt_q <= last_edge ? 6'd0 : edge_cnt_q + 6'd1;
        if (edge_cnt_q == half - 6'd2) samp_q[0] <= sync2_q;
        if (edge_cnt_q == half - 6'd1) samp_q[1] <= sync2_q;
        if (edge_cnt_q == half)        samp_q[2] <= sync2_q;
      end

      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q    <= START;
            edge_cnt_q <= '0;
            presc_q    <= presc_d;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            par_flag_q <= 1'b0;
          end
        end
        START: begin
          if (last_edge) begin
            if (bit_d) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
        end
        DATA: begin
          if (last_edge) begin
            shift_q <= shift_d;
            if (bit_cnt_q == LAST_BIT) state_q <= par_en_q ? PARITY : STOP;
            else                       bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_flag_q <= bit_d ^ par_exp_d;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            stop_bad_q <= ~bit_d;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA   = p_data_q;
  assign bus.data_vld = data_vld_q;
  assign bus.par_err  = par_err_q;
  assign bus.stp_err  = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives oversampled frames and scores the result
// pulses against directed expectations and a frame-level reference model.
module tb_uart_rx;
  localparam int DW = 8;

  typedef struct {
    logic [5:0] presc;
    bit         pe;
    bit         pt;
  } cfg_t;

  typedef struct {
    bit          vld;
    bit          perr;
    bit          serr;
    logic [DW-1:0] data;
    int unsigned cyc;
  } ev_t;

  typedef struct {
    bit          vld;
    bit          perr;
    bit          serr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned   cyc = 0;
  ev_t           act_q[$];
  exp_t          exp_q[$];
  ev_t           mon_ev;
  logic [DW-1:0] model_pdata = '0;
  int            checks = 0;
  int            errors = 0;
  int            mid_at = -1;
  cfg_t          mid_cfg;
  int            rst_at = -1;
  logic [10:0]   rst_snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Every result pulse is logged with the cycle it became visible.
  always @(negedge clk) begin
    if (bus.data_vld === 1'b1 || bus.par_err === 1'b1 || bus.stp_err === 1'b1) begin
      mon_ev.vld  = bus.data_vld;
      mon_ev.perr = bus.par_err;
      mon_ev.serr = bus.stp_err;
      mon_ev.data = bus.P_DATA;
      mon_ev.cyc  = cyc;
      act_q.push_back(mon_ev);
    end
  end

  function automatic int eff_p(input logic [5:0] ps);
    if (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) return int'(ps);
    return 8;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
    end
  endtask

  task automatic settle(input int n_exp, input int budget);
    int k;
    k = 0;
    while (act_q.size() < n_exp && k < budget) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
      k++;
    end
    idle(80);
  endtask

  // Drives one frame, one line value per clock, and records the model's expected result.
  task automatic send_frame(input logic [DW-1:0] data, input cfg_t cfg, input bit par_bad,
                            input bit stop_bit, input bit glitch, output int unsigned st);
    int   p;
    bit   par_ok, par_sent;
    bit   bits[$];
    exp_t e;
    p        = eff_p(cfg.presc);
    par_ok   = bit'(($countones(data) + int'(cfg.pt)) % 2);
    par_sent = par_ok ^ par_bad;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (cfg.pe) bits.push_back(par_sent);
    bits.push_back(stop_bit);
    st = 0;
    for (int c = 0; c < bits.size() * p; c++) begin
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1)
        rst_snap = {bus.data_vld, bus.par_err, bus.stp_err, bus.P_DATA};
      if (c == 0) begin
        bus.Prescale = cfg.presc;
        bus.PAR_EN   = cfg.pe;
        bus.PAR_TYP  = cfg.pt;
        st           = cyc;
      end
      if (c == mid_at) begin
        bus.Prescale = mid_cfg.presc;
        bus.PAR_EN   = mid_cfg.pe;
        bus.PAR_TYP  = mid_cfg.pt;
      end
      reset     = (c == rst_at);
      bus.RX_IN = bits[c / p] ^ (glitch && (c % p == p / 2));
    end
    if (rst_at >= 0) begin
      model_pdata = '0;
    end else begin
      e.serr = (stop_bit == 1'b0);
      e.perr = cfg.pe && ((($countones(data) + int'(par_sent)) % 2) != int'(cfg.pt));
      e.vld  = !e.serr && !e.perr;
      if (e.vld) model_pdata = data;
      e.data = model_pdata;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.RX_IN    = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", bus.P_DATA); end
    checks++;
    if (bus.data_vld !== 1'b0) begin errors++; $display("FAIL reset_data_vld: got %b want 0", bus.data_vld); end
    checks++;
    if (bus.par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b want 0", bus.par_err); end
    checks++;
    if (bus.stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b want 0", bus.stp_err); end
    reset = 1'b0;
    model_pdata = '0;
    act_q.delete();
    settle(0, 0);
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL reset_idle_quiet: got %0d pulses want 0", act_q.size()); end
  endtask

  task automatic test_parity();
    cfg_t        cfg;
    int unsigned st, st0;
    logic [10:0] want[4];
    want = '{{3'b100, 8'hA5}, {3'b010, 8'hA5}, {3'b010, 8'hA5}, {3'b100, 8'hA5}};
    act_q.delete();
    cfg = '{presc: 6'd8, pe: 1'b1, pt: 1'b0};
    send_frame(8'hA5, cfg, 1'b0, 1'b1, 1'b0, st0);
    idle(5);
    send_frame(8'hA5, cfg, 1'b1, 1'b1, 1'b0, st);
    idle(5);
    send_frame(8'h3C, cfg, 1'b1, 1'b1, 1'b0, st);
    idle(5);
    cfg.pt = 1'b1;
    send_frame(8'hA5, cfg, 1'b0, 1'b1, 1'b0, st);
    settle(4, 400);
    checks++;
    if (act_q.size() != 4) begin
      errors++; $display("FAIL parity_count: got %0d want 4", act_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data} !== want[i]) begin
          errors++;
          $display("FAIL parity_ev%0d: got %b want %b", i,
                   {act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data}, want[i]);
        end
      end
      checks++;
      if (act_q[0].cyc - st0 != 32'd92) begin
        errors++; $display("FAIL parity_latency: got %0d want 92", act_q[0].cyc - st0);
      end
    end
  endtask

  task automatic test_stop_back_to_back();
    cfg_t        cfg;
    int unsigned st;
    logic [10:0] want[2];
    want = '{{3'b001, 8'hA5}, {3'b100, 8'h3C}};
    act_q.delete();
    cfg = '{presc: 6'd16, pe: 1'b0, pt: 1'b0};
    send_frame(8'h3C, cfg, 1'b0, 1'b0, 1'b0, st);
    send_frame(8'h3C, cfg, 1'b0, 1'b1, 1'b0, st);
    settle(2, 400);
    checks++;
    if (act_q.size() != 2) begin
      errors++; $display("FAIL stop_count: got %0d want 2", act_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data} !== want[i]) begin
          errors++;
          $display("FAIL stop_ev%0d: got %b want %b", i,
                   {act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data}, want[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    cfg_t        cfg;
    int unsigned st;
    act_q.delete();
    cfg = '{presc: 6'd32, pe: 1'b0, pt: 1'b0};
    send_frame(8'h81, cfg, 1'b0, 1'b1, 1'b1, st);
    settle(1, 400);
    checks++;
    if (act_q.size() != 1) begin
      errors++; $display("FAIL glitch_count: got %0d want 1", act_q.size());
    end else begin
      checks++;
      if ({act_q[0].vld, act_q[0].perr, act_q[0].serr, act_q[0].data} !== {3'b100, 8'h81}) begin
        errors++;
        $display("FAIL glitch_vote: got %b want %b",
                 {act_q[0].vld, act_q[0].perr, act_q[0].serr, act_q[0].data}, {3'b100, 8'h81});
      end
    end
    act_q.delete();
    repeat (5) begin
      @(negedge clk);
      bus.RX_IN = 1'b0;
    end
    settle(0, 0);
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL false_start: got %0d pulses want 0", act_q.size()); end
    checks++;
    if (bus.P_DATA !== 8'h81) begin errors++; $display("FAIL false_start_hold: got %h want 81", bus.P_DATA); end
  endtask

  task automatic test_cfg_change();
    cfg_t        cfg;
    int unsigned st;
    logic [10:0] want[2];
    want = '{{3'b100, 8'h96}, {3'b100, 8'h4B}};
    act_q.delete();
    cfg     = '{presc: 6'd8, pe: 1'b1, pt: 1'b0};
    mid_cfg = '{presc: 6'd16, pe: 1'b0, pt: 1'b1};
    mid_at  = 30;
    send_frame(8'h96, cfg, 1'b0, 1'b1, 1'b0, st);
    mid_at  = -1;
    idle(5);
    send_frame(8'h4B, mid_cfg, 1'b0, 1'b1, 1'b0, st);
    settle(2, 400);
    checks++;
    if (act_q.size() != 2) begin
      errors++; $display("FAIL cfg_count: got %0d want 2", act_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data} !== want[i]) begin
          errors++;
          $display("FAIL cfg_ev%0d: got %b want %b", i,
                   {act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data}, want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    cfg_t        cfg;
    int unsigned st;
    act_q.delete();
    cfg    = '{presc: 6'd8, pe: 1'b0, pt: 1'b0};
    rst_at = 6 * 8 + 4;
    send_frame(8'hF0, cfg, 1'b0, 1'b1, 1'b0, st);
    rst_at = -1;
    settle(0, 0);
    checks++;
    if (rst_snap !== 11'd0) begin errors++; $display("FAIL midreset_outputs: got %b want 0", rst_snap); end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL midreset_quiet: got %0d pulses want 0", act_q.size()); end
    send_frame(8'h5A, cfg, 1'b0, 1'b1, 1'b0, st);
    settle(1, 400);
    checks++;
    if (act_q.size() != 1) begin
      errors++; $display("FAIL midreset_next_count: got %0d want 1", act_q.size());
    end else begin
      checks++;
      if ({act_q[0].vld, act_q[0].perr, act_q[0].serr, act_q[0].data} !== {3'b100, 8'h5A}) begin
        errors++;
        $display("FAIL midreset_next: got %b want %b",
                 {act_q[0].vld, act_q[0].perr, act_q[0].serr, act_q[0].data}, {3'b100, 8'h5A});
      end
    end
  endtask

  task automatic test_break();
    int          k;
    int unsigned st, d;
    act_q.delete();
    @(negedge clk);
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.RX_IN    = 1'b0;
    st = cyc;
    k  = 0;
    while (act_q.size() < 3 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    bus.RX_IN = 1'b1;
    settle(3, 0);
    checks++;
    if (act_q.size() != 3) begin
      errors++; $display("FAIL break_count: got %0d want 3", act_q.size());
    end else begin
      checks++;
      if (act_q[0].cyc - st != 32'd84) begin
        errors++; $display("FAIL break_first: got %0d want 84", act_q[0].cyc - st);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data} !== {3'b001, 8'h5A}) begin
          errors++;
          $display("FAIL break_ev%0d: got %b want %b", i,
                   {act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data}, {3'b001, 8'h5A});
        end
      end
      for (int i = 1; i < 3; i++) begin
        d = act_q[i].cyc - act_q[i-1].cyc;
        checks++;
        if (d < 80 || d > 81) begin
          errors++; $display("FAIL break_period%0d: got %0d want 80..81", i, d);
        end
      end
    end
  endtask

  task automatic test_random();
    cfg_t        cfg;
    int unsigned st;
    int          n;
    logic [5:0]  ptab[9];
    ptab = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd0, 6'd12, 6'd63};
    act_q.delete();
    exp_q.delete();
    for (int f = 0; f < 24; f++) begin
      cfg.presc = ptab[$urandom_range(0, 8)];
      cfg.pe    = bit'($urandom_range(0, 1));
      cfg.pt    = bit'($urandom_range(0, 1));
      send_frame(DW'($urandom), cfg, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0), 1'b0, st);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 15));
    end
    settle(exp_q.size(), 2000);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data} !==
          {exp_q[i].vld, exp_q[i].perr, exp_q[i].serr, exp_q[i].data}) begin
        errors++;
        $display("FAIL random_ev%0d: got %b want %b", i,
                 {act_q[i].vld, act_q[i].perr, act_q[i].serr, act_q[i].data},
                 {exp_q[i].vld, exp_q[i].perr, exp_q[i].serr, exp_q[i].data});
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_stop_back_to_back();
    test_glitch();
    test_cfg_change();
    test_reset_mid_frame();
    test_break();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
